mem_bus_arbiter: RTL and testbench

- Shares the single 8-bit synchronous-read program/data memory between two requesters.
- Port 0 is the CPU control unit's MAR/memory-bus path. Port 1 is the UART program loader / debug DMA.
- Round-robin arbitration with one transaction per grant; a Moore FSM sequences the issue and ack phases.
- Sits between the control unit / loader and the memory; the memory itself is unchanged.

---
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port round-robin arbiter in front of the single
// 8-bit synchronous-read program/data memory. Port 0 is the CPU memory-bus
// path, port 1 is the UART loader / debug DMA.
// Optional build macro: ARB_LOCK_EN adds lock0/lock1 so a requester can keep
// the bus across consecutive transactions (atomic multi-byte loader writes).
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
// them until ackN. gntN is high for the ISSUE and ACK cycles of its
// transaction; ackN is a one-cycle pulse in the ACK cycle, and for reads
// rdata carries the memory word in that same cycle. In the cycle after ackN
// the requester either drops reqN or presents its next request. A request
// dropped after it was accepted still completes and still gets its ack.
module mem_bus_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          ack1,
`ifdef ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t        current_state;
    state_t        next_state;
    logic          owner;
    logic          owner_next;
    logic          last;
    logic          last_next;
    logic [AW-1:0] addr_q;

    logic          any_req;
    logic          rr_owner;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef ARB_LOCK_EN
    logic          locked;
    logic          locked_next;
    logic          sel_req;
    logic          sel_lock;

    assign sel_req  = owner ? req1  : req0;
    assign sel_lock = owner ? lock1 : lock0;
`endif

    // Owner-side request fields; the owner is fixed for the whole transaction.
    assign sel_we    = owner ? we1    : we0;
    assign sel_addr  = owner ? addr1  : addr0;
    assign sel_wdata = owner ? wdata1 : wdata0;

    // Round-robin pick: a lone requester wins, a tie goes away from the last winner.
    assign any_req  = req0 | req1;
    assign rr_owner = (req0 & req1) ? ~last : req1;

    assign dbg_state = current_state;

    // State, owner and round-robin history; reset leaves port 0 winning the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_state <= S_IDLE;
            owner         <= 1'b0;
            last          <= 1'b1;
`ifdef ARB_LOCK_EN
            locked        <= 1'b0;
`endif
        end else begin
            current_state <= next_state;
            owner         <= owner_next;
            last          <= last_next;
`ifdef ARB_LOCK_EN
            locked        <= locked_next;
`endif
        end
    end

    // Capture the issued address so mem_addr stays put through ACK even if the requester moves on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else if (current_state == S_ISSUE) begin
            addr_q <= sel_addr;
        end
    end

    // Next-state and Moore outputs, all derived from state and owner.
    always_comb begin
        next_state  = current_state;
        owner_next  = owner;
        last_next   = last;
`ifdef ARB_LOCK_EN
        locked_next = locked;
`endif
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        rdata       = '0;

        case (current_state)
            S_IDLE: begin
`ifdef ARB_LOCK_EN
                if (locked && sel_req && sel_lock) begin
                    next_state = S_ISSUE;
                end else begin
                    locked_next = 1'b0;
                    if (any_req) begin
                        next_state = S_ISSUE;
                        owner_next = rr_owner;
                    end
                end
`else
                if (any_req) begin
                    next_state = S_ISSUE;
                    owner_next = rr_owner;
                end
`endif
            end
            S_ISSUE: begin
                gnt0       = ~owner;
                gnt1       = owner;
                mem_addr   = sel_addr;
                mem_wdata  = sel_wdata;
                mem_we     = sel_we;
                next_state = S_ACK;
            end
            S_ACK: begin
                gnt0       = ~owner;
                gnt1       = owner;
                ack0       = ~owner;
                ack1       = owner;
                mem_addr   = addr_q;
                rdata      = mem_rdata;
                last_next  = owner;
`ifdef ARB_LOCK_EN
                locked_next = sel_lock;
`endif
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with cycle-exact checks, then
// randomized traffic on both ports checked by a scoreboard against a
// reference memory. Port 0 traffic stays in 0x40-0x7F and port 1 in
// 0xC0-0xFF so each port's expected read data depends only on its own order.
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, ack0, gnt1, ack1;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
    logic [1:0] dbg_state;
`ifdef ARB_LOCK_EN
    logic       lock0, lock1;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [8:0]  exp_q0[$];
    logic [8:0]  exp_q1[$];
    logic [15:0] wq0[$];
    logic [15:0] wq1[$];
    bit          mon_en = 1'b0;
    int          wait_max = 0;

    mem_bus_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .ack1(ack1),
`ifdef ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'hB5;
    endfunction

    // Synchronous-read memory: data for the address seen at an edge appears after it.
    initial begin : mem_model
        for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: event seen, required none", name);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    // Issue one transaction on port p and wait (bounded) for its ack.
    task automatic port_txn(input bit p, input logic w, input logic [7:0] a, input logic [7:0] d);
        logic [8:0] e;
        bit         seen;
        if (w) begin
            ref_mem[a] = d;
            e = {1'b1, 8'h00};
        end else begin
            e = {1'b0, ref_mem[a]};
        end
        if (!p) begin
            exp_q0.push_back(e);
            if (w) wq0.push_back({a, d});
            we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            exp_q1.push_back(e);
            if (w) wq1.push_back({a, d});
            we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = p ? ack1 : ack0;
        end
        if (!seen) begin
            vectors++;
            errors++;
            $display("FAIL ack_timeout: port %0d got no ack in 20 cycles, required one", p);
        end
        if (!p) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic run_port(input bit p, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            port_txn(p, 1'($urandom_range(0, 1)),
                     p ? 8'hC0 + 8'($urandom_range(0, 63)) : 8'h40 + 8'($urandom_range(0, 63)),
                     8'($urandom));
        end
    endtask

    initial begin : main
        int         got[$];
        int         expo[$];
        int         lastw;
        int         dual;
        int         n1;
        logic [8:0] e;
        logic [15:0] we_exp;
        int         w0, w1;

        reset = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
`ifdef ARB_LOCK_EN
        lock0 = 0; lock1 = 0;
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

        // Scoreboard monitor: runs independently of the stimulus.
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    check("grant_exclusive", 32'(gnt0 & gnt1), 0);
                    if (mem_we) begin
                        if (gnt0 && wq0.size() > 0) begin
                            we_exp = wq0.pop_front();
                            check("write_p0", {mem_addr, mem_wdata}, 32'(we_exp));
                        end else if (gnt1 && wq1.size() > 0) begin
                            we_exp = wq1.pop_front();
                            check("write_p1", {mem_addr, mem_wdata}, 32'(we_exp));
                        end else begin
                            fail_event("unexpected_write");
                        end
                    end
                    if (ack0) begin
                        check("we_low_in_ack", 32'(mem_we), 0);
                        if (exp_q0.size() == 0) fail_event("unexpected_ack0");
                        else begin
                            e = exp_q0.pop_front();
                            if (!e[8]) check("rdata_p0", 32'(rdata), 32'(e[7:0]));
                        end
                    end
                    if (ack1) begin
                        check("we_low_in_ack", 32'(mem_we), 0);
                        if (exp_q1.size() == 0) fail_event("unexpected_ack1");
                        else begin
                            e = exp_q1.pop_front();
                            if (!e[8]) check("rdata_p1", 32'(rdata), 32'(e[7:0]));
                        end
                    end
                    w0 = (req0 && !gnt0) ? w0 + 1 : 0;
                    w1 = (req1 && !gnt1) ? w1 + 1 : 0;
                    if (w0 > wait_max) wait_max = w0;
                    if (w1 > wait_max) wait_max = w1;
                end
            end
        join_none
        w0 = 0;
        w1 = 0;

        // Reset state, during and just after reset
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_outputs", {gnt0, gnt1, ack0, ack1, mem_we, mem_addr, mem_wdata, rdata}, 0);
        check("reset_state", 32'(dbg_state), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("idle_outputs", {gnt0, gnt1, ack0, ack1, mem_we, mem_addr, rdata}, 0);

        // Single read of preloaded 0x10 on port 0
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        check("rd_issue_gnt", {gnt0, gnt1, ack0, mem_we}, 4'b1000);
        check("rd_issue_addr", 32'(mem_addr), 32'h10);
        tick();
        check("rd_ack_gnt", {gnt0, gnt1, ack0, ack1, mem_we}, 5'b10100);
        check("rd_ack_rdata", 32'(rdata), 32'hA5);
        req0 = 0;
        tick();
        check("rd_back_idle", {30'(dbg_state), gnt0, ack0}, 0);

        // Single write on port 1, then read it back on port 0
        req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h3C;
        tick();
        check("wr_issue", {gnt1, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h20, 8'h3C});
        tick();
        check("wr_ack", {ack1, mem_we}, 2'b10);
        req1 = 0;
        ref_mem[8'h20] = 8'h3C;
        tick();
        check("wr_idle_we", 32'(mem_we), 0);
        req0 = 1; we0 = 0; addr0 = 8'h20;
        tick();
        tick();
        check("wr_readback", {ack0, rdata}, {1'b1, 8'h3C});
        req0 = 0;
        tick();

        // Contention: both requesters held for 12 cycles after reset
        apply_reset();
        req0 = 1; we0 = 0; addr0 = 8'h10;
        req1 = 1; we1 = 0; addr1 = 8'h20;
        got.delete();
        dual = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gnt0 && gnt1) dual++;
            if (ack0) got.push_back(0);
            if (ack1) got.push_back(1);
        end
        req0 = 0; req1 = 0;
        expo.delete();
        lastw = 1;
        for (int i = 0; i < 4; i++) begin
            lastw = 1 - lastw;
            expo.push_back(lastw);
        end
        check("contention_ack_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            check("contention_order", (i < got.size()) ? got[i] : 9, expo[i]);
        check("contention_dual_grant", dual, 0);
        tick();

        // Reset asserted while a write is in ISSUE
        req1 = 1; we1 = 1; addr1 = 8'h30; wdata1 = 8'h77;
        tick();
        check("rst_pre_issue", {gnt1, mem_we}, 2'b11);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_drop", {gnt0, gnt1, mem_we, 2'b00, dbg_state}, 0);
        req1 = 0;
        n1 = 0;
        repeat (2) begin
            tick();
            if (ack0 || ack1) n1++;
        end
        check("rst_no_ack", n1, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        req0 = 1; we0 = 0; addr0 = 8'h10;
        req1 = 1; we1 = 0; addr1 = 8'h20;
        tick();
        check("rst_first_tie", {gnt0, gnt1}, 2'b10);
        tick();
        check("rst_tie_ack", {ack0, ack1}, 2'b10);
        req0 = 0; req1 = 0;
        tick();

        // Requester drops req0 during ISSUE
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        req0 = 0;
        tick();
        check("drop_ack", {ack0, rdata}, {1'b1, 8'hA5});
        tick();
        check("drop_idle", 32'(dbg_state), 0);
        tick();
        check("drop_no_retry", {gnt0, gnt1, 2'b00, dbg_state}, 0);

`ifdef ARB_LOCK_EN
        // Lock: port 1 keeps the bus for three transactions, then port 0 wins
        apply_reset();
        req1 = 1; we1 = 0; addr1 = 8'h20; lock1 = 1;
        got.delete();
        n1 = 0;
        for (int i = 0; i < 30 && got.size() < 4; i++) begin
            tick();
            if (ack0) got.push_back(0);
            if (ack1) begin
                got.push_back(1);
                n1++;
                if (n1 == 1) begin
                    req0 = 1; we0 = 0; addr0 = 8'h10;
                end
                if (n1 == 3) lock1 = 0;
            end
        end
        req0 = 0; req1 = 0; lock1 = 0;
        expo.delete();
        expo.push_back(1); expo.push_back(1); expo.push_back(1); expo.push_back(0);
        for (int i = 0; i < 4; i++)
            check("lock_order", (i < got.size()) ? got[i] : 9, expo[i]);
        tick();
`endif

        // Randomized traffic on both ports against the scoreboard
        mon_en = 1'b1;
        fork
            run_port(1'b0, 40);
            run_port(1'b1, 40);
        join
        for (int i = 0; i < 10 && (exp_q0.size() + exp_q1.size() + wq0.size() + wq1.size()) != 0; i++)
            tick();
        tick();
        mon_en = 1'b0;
        check("rand_exp_q0_drained", exp_q0.size(), 0);
        check("rand_exp_q1_drained", exp_q1.size(), 0);
        check("rand_writes_drained", wq0.size() + wq1.size(), 0);
        check("rand_max_wait_le6", 32'(wait_max <= 6), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
